// File: rtl/line_editor.sv
// rtl/line_editor.sv - cursor-tracking line editor driving an insert/remove character vector
// Key events are accepted in IDLE, edits become one-cycle strobes, and the cursor follows on completion.
module line_editor #(
    parameter int DATA_WIDTH   = 7,
    parameter int DATA_COUNT   = 127,
    parameter int INDEX_WIDTH  = $clog2(DATA_COUNT),
    parameter int LENGTH_WIDTH = $clog2(DATA_COUNT + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    key_valid,
    input  logic [2:0]              key_kind,
    input  logic [DATA_WIDTH-1:0]   key_char,
    output logic                    key_ready,
    output logic [LENGTH_WIDTH-1:0] cursor,
    output logic [INDEX_WIDTH-1:0]  vec_index,
    output logic                    vec_insert,
    output logic                    vec_remove,
    output logic [DATA_WIDTH-1:0]   vec_data,
    input  logic [LENGTH_WIDTH-1:0] vec_length,
    input  logic                    vec_ready
);

    localparam logic [2:0] KIND_CHAR      = 3'd0;
    localparam logic [2:0] KIND_BACKSPACE = 3'd1;
    localparam logic [2:0] KIND_DELETE    = 3'd2;
    localparam logic [2:0] KIND_LEFT      = 3'd3;
    localparam logic [2:0] KIND_RIGHT     = 3'd4;
    localparam logic [2:0] KIND_HOME      = 3'd5;
    localparam logic [2:0] KIND_END       = 3'd6;

    localparam logic [LENGTH_WIDTH-1:0] FULL_LENGTH = LENGTH_WIDTH'(DATA_COUNT);
    localparam logic [LENGTH_WIDTH-1:0] LENGTH_ONE  = LENGTH_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    typedef enum logic [1:0] {
        OP_INSERT,
        OP_BACKSPACE,
        OP_DELETE
    } op_t;

    state_t                  state;
    state_t                  state_next;
    op_t                     op;
    op_t                     op_next;
    logic                    settle;
    logic                    settle_next;
    logic                    accept;
    logic [LENGTH_WIDTH-1:0] cursor_next;
    logic [INDEX_WIDTH-1:0]  index_next;
    logic [DATA_WIDTH-1:0]   data_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            op        <= OP_INSERT;
            settle    <= 1'b0;
            cursor    <= '0;
            vec_index <= '0;
            vec_data  <= '0;
        end else begin
            state     <= state_next;
            op        <= op_next;
            settle    <= settle_next;
            cursor    <= cursor_next;
            vec_index <= index_next;
            vec_data  <= data_next;
        end
    end

    always_comb begin
        state_next  = state;
        op_next     = op;
        settle_next = 1'b0;
        cursor_next = cursor;
        index_next  = vec_index;
        data_next   = vec_data;
        vec_insert  = 1'b0;
        vec_remove  = 1'b0;
        key_ready   = (state == IDLE) && vec_ready;
        accept      = key_valid && key_ready;

        case (state)
            IDLE: begin
                // Events that hit a boundary fall through with nothing changed.
                if (accept) begin
                    case (key_kind)
                        KIND_CHAR: begin
                            if (vec_length < FULL_LENGTH) begin
                                data_next  = key_char;
                                index_next = INDEX_WIDTH'(cursor);
                                op_next    = OP_INSERT;
                                state_next = ISSUE;
                            end
                        end
                        KIND_BACKSPACE: begin
                            if (cursor != '0) begin
                                index_next = INDEX_WIDTH'(cursor - LENGTH_ONE);
                                op_next    = OP_BACKSPACE;
                                state_next = ISSUE;
                            end
                        end
                        KIND_DELETE: begin
                            if (cursor < vec_length) begin
                                index_next = INDEX_WIDTH'(cursor);
                                op_next    = OP_DELETE;
                                state_next = ISSUE;
                            end
                        end
                        KIND_LEFT: begin
                            if (cursor != '0) begin
                                cursor_next = cursor - LENGTH_ONE;
                            end
                        end
                        KIND_RIGHT: begin
                            if (cursor < vec_length) begin
                                cursor_next = cursor + LENGTH_ONE;
                            end
                        end
                        KIND_HOME: cursor_next = '0;
                        KIND_END:  cursor_next = vec_length;
                        default: ;
                    endcase
                end
            end
            ISSUE: begin
                vec_insert  = (op == OP_INSERT);
                vec_remove  = (op != OP_INSERT);
                settle_next = 1'b1;
                state_next  = WAIT;
            end
            WAIT: begin
                // The vector reports ready only from the second cycle after a strobe.
                if (!settle && vec_ready) begin
                    state_next = IDLE;
                    case (op)
                        OP_INSERT:    cursor_next = cursor + LENGTH_ONE;
                        OP_BACKSPACE: cursor_next = cursor - LENGTH_ONE;
                        default: ;
                    endcase
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_line_editor.sv
// tb/tb_line_editor.sv - scoreboard bench for line_editor with a behavioural character vector
module tb_line_editor;

    localparam logic [2:0] K_CHAR = 3'd0;
    localparam logic [2:0] K_BS   = 3'd1;
    localparam logic [2:0] K_DEL  = 3'd2;
    localparam logic [2:0] K_LEFT = 3'd3;
    localparam logic [2:0] K_RGT  = 3'd4;
    localparam logic [2:0] K_HOME = 3'd5;
    localparam logic [2:0] K_END  = 3'd6;
    localparam logic [2:0] K_RSV  = 3'd7;

    logic       clk;
    logic       reset;
    logic       key_valid;
    logic [2:0] key_kind;
    logic [6:0] key_char;
    logic       key_ready;
    logic [6:0] cursor;
    logic [6:0] vec_index;
    logic       vec_insert;
    logic       vec_remove;
    logic [6:0] vec_data;
    logic [6:0] vec_length;
    logic       vec_ready;

    typedef struct {
        bit ins;
        int idx;
        int data;
    } strobe_t;

    strobe_t    exp_q[$];
    logic [6:0] mem[$];
    int         busy;
    int         checks;
    int         errors;

    line_editor dut (
        .clk        (clk),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_kind   (key_kind),
        .key_char   (key_char),
        .key_ready  (key_ready),
        .cursor     (cursor),
        .vec_index  (vec_index),
        .vec_insert (vec_insert),
        .vec_remove (vec_remove),
        .vec_data   (vec_data),
        .vec_length (vec_length),
        .vec_ready  (vec_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream vector: busy for a few cycles after each strobe, ready low the cycle after it.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mem.delete();
            busy = 0;
            vec_ready  <= 1'b1;
            vec_length <= '0;
        end else if (vec_insert) begin
            mem.insert(int'(vec_index), vec_data);
            busy = int'(vec_index) % 3;
            vec_ready  <= 1'b0;
            vec_length <= 7'(mem.size());
        end else if (vec_remove) begin
            mem.delete(int'(vec_index));
            busy = int'(vec_index) % 3;
            vec_ready  <= 1'b0;
            vec_length <= 7'(mem.size());
        end else if (busy > 0) begin
            busy--;
        end else begin
            vec_ready <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!reset && (vec_insert || vec_remove)) begin
            check("strobe_exclusive", int'(vec_insert & vec_remove), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", exp_q.size(), 1);
            end else begin
                strobe_t e;
                e = exp_q.pop_front();
                check("strobe_kind", int'(vec_insert), int'(e.ins));
                check("strobe_index", int'(vec_index), e.idx);
                if (e.ins) check("strobe_data", int'(vec_data), e.data);
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!key_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", int'(key_ready), 1);
    endtask

    // strobe: 0 none, 1 insert, 2 remove
    task automatic send_key(input logic [2:0] kind, input logic [6:0] ch, input int strobe, input int idx);
        strobe_t e;
        wait_ready();
        if (strobe != 0) begin
            e.ins  = (strobe == 1);
            e.idx  = idx;
            e.data = int'(ch);
            exp_q.push_back(e);
        end
        key_valid = 1'b1;
        key_kind  = kind;
        key_char  = ch;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_kind  = 3'($urandom_range(7, 0));
        key_char  = 7'($urandom_range(127, 0));
        @(negedge clk);
        check("strobe_latency", int'(vec_insert | vec_remove), int'(strobe != 0));
    endtask

    task automatic op(input logic [2:0] kind, input logic [6:0] ch, input int strobe, input int idx, input int exp_cursor);
        send_key(kind, ch, strobe, idx);
        wait_ready();
        check("cursor", int'(cursor), exp_cursor);
    endtask

    task automatic check_mem(input string s);
        check("vec_length", int'(vec_length), s.len());
        check("vec_size", mem.size(), s.len());
        for (int i = 0; i < s.len() && i < mem.size(); i++) begin
            check("vec_char", int'(mem[i]), int'(s[i]));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        key_valid = 1'b0;
        key_kind  = K_CHAR;
        key_char  = '0;
        repeat (2) @(negedge clk);
        check("reset_cursor", int'(cursor), 0);
        check("reset_index", int'(vec_index), 0);
        check("reset_data", int'(vec_data), 0);
        check("reset_strobes", int'(vec_insert | vec_remove), 0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", int'(key_ready), 1);

        op(K_CHAR, 7'h41, 1, 0, 1);
        op(K_CHAR, 7'h42, 1, 1, 2);
        check_mem("AB");

        op(K_LEFT, 7'h00, 0, 0, 1);
        op(K_CHAR, 7'h58, 1, 1, 2);
        check_mem("AXB");

        op(K_BS,   7'h00, 2, 1, 1);
        check_mem("AB");
        op(K_HOME, 7'h00, 0, 0, 0);
        op(K_BS,   7'h00, 0, 0, 0);
        op(K_LEFT, 7'h00, 0, 0, 0);
        check_mem("AB");

        op(K_END,  7'h00, 0, 0, 2);
        op(K_DEL,  7'h00, 0, 0, 2);
        op(K_RGT,  7'h00, 0, 0, 2);
        op(K_RSV,  7'h41, 0, 0, 2);
        op(K_LEFT, 7'h00, 0, 0, 1);
        check_mem("AB");

        // DELETE with key_valid held high: kind changes after acceptance and must not matter.
        wait_ready();
        exp_q.push_back('{ins: 1'b0, idx: 1, data: 0});
        key_valid = 1'b1;
        key_kind  = K_DEL;
        @(posedge clk);
        #1;
        key_kind = K_HOME;
        n = 0;
        @(negedge clk);
        check("hold_strobe", int'(vec_remove), 1);
        while (!key_ready && n < 100) begin
            check("hold_index", int'(vec_index), 1);
            n++;
            @(negedge clk);
        end
        check("hold_busy_cycles", n, 4);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        @(negedge clk);
        check("hold_cursor", int'(cursor), 0);
        check("hold_single_remove", exp_q.size(), 0);
        check_mem("A");

        op(K_END, 7'h00, 0, 0, 1);
        for (int i = 0; i < 126; i++) begin
            op(K_CHAR, 7'(33 + (i % 90)), 1, 1 + i, 2 + i);
        end
        check("full_length", int'(vec_length), 127);
        send_key(K_CHAR, 7'h46, 0, 0);
        check("full_ready_next", int'(key_ready), 1);
        check("full_cursor", int'(cursor), 127);

        op(K_BS, 7'h00, 2, 126, 126);
        send_key(K_CHAR, 7'h5a, 1, 126);
        @(posedge clk);
        #1;
        check("in_wait", int'(key_ready), 0);
        #1;
        reset = 1'b1;
        #1;
        check("async_strobes", int'(vec_insert | vec_remove), 0);
        check("async_cursor", int'(cursor), 0);
        check("async_index", int'(vec_index), 0);
        check("async_data", int'(vec_data), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_abort", int'(key_ready), 1);
        check("vector_cleared", int'(vec_length), 0);

        op(K_CHAR, 7'h51, 1, 0, 1);
        check_mem("Q");
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
